// File: rtl/mc_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_alu_pkg                                                           |
// | Command encodings and FSM state type for the multicycle ALU.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package mc_alu_pkg;

    localparam logic [3:0] CMD_ADD   = 4'b0000;
    localparam logic [3:0] CMD_SUB   = 4'b0010;
    localparam logic [3:0] CMD_AND   = 4'b0100;
    localparam logic [3:0] CMD_OR    = 4'b0101;
    localparam logic [3:0] CMD_NOR   = 4'b0110;
    localparam logic [3:0] CMD_XOR   = 4'b0111;
    localparam logic [3:0] CMD_SLL   = 4'b1000;
    localparam logic [3:0] CMD_SRA   = 4'b1001;
    localparam logic [3:0] CMD_SRL   = 4'b1010;
    localparam logic [3:0] CMD_SLT   = 4'b1011;
    localparam logic [3:0] CMD_MULTU = 4'b1100;
    localparam logic [3:0] CMD_DIVU  = 4'b1101;
    localparam logic [3:0] CMD_MULT  = 4'b1110;
    localparam logic [3:0] CMD_DIV   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mc_alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_alu_muldiv                                                        |
// | Iterative unsigned shift-add multiplier / restoring divider.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mc_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_div;
    logic [CNTW-1:0]  r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_trial = {r_hi, r_lo[WIDTH-1]};
        w_ge    = (w_trial >= {1'b0, r_b});
        w_diff  = w_trial[WIDTH-1:0] - r_b;
        if (r_div) begin
            nxt_hi = w_ge ? w_diff : w_trial[WIDTH-1:0];
            nxt_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            nxt_hi = w_sum[WIDTH:1];
            nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign last = (r_cnt == CNTW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (load) begin
            r_hi  <= '0;
            r_lo  <= a;
            r_b   <= b;
            r_div <= is_div;
            r_cnt <= CNTW'(WIDTH);
        end else if (step) begin
            r_hi  <= nxt_hi;
            r_lo  <= nxt_lo;
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_alu                                                               |
// | Multicycle ALU: registered single-cycle ops plus iterative mul/div.  |
// | Option: MC_ALU_SIGNED_MULDIV_EN adds signed mult/div (cmd 1110/1111).|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic             w_signed;
    logic             w_is_mul;
    logic             w_is_muldiv;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_md_load;
    logic             w_md_step;
    logic             w_md_last;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_shamt = in2[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (cmd)
            CMD_ADD: w_alu = in1 + in2;
            CMD_SUB: w_alu = in1 - in2;
            CMD_AND: w_alu = in1 & in2;
            CMD_OR:  w_alu = in1 | in2;
            CMD_NOR: w_alu = ~(in1 | in2);
            CMD_XOR: w_alu = in1 ^ in2;
            CMD_SLL: w_alu = in1 << w_shamt;
            CMD_SRA: w_alu = $signed(in1) >>> w_shamt;
            CMD_SRL: w_alu = in1 >> w_shamt;
            CMD_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            default: w_alu = '0;
        endcase
    end

`ifdef MC_ALU_SIGNED_MULDIV_EN
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] w_prod;

    // Signed ops run on magnitudes; the sign flags fix the result on completion.
    assign w_signed = (cmd == CMD_MULT) || (cmd == CMD_DIV);
    assign w_a      = (w_signed && in1[WIDTH-1]) ? -in1 : in1;
    assign w_b      = (w_signed && in2[WIDTH-1]) ? -in2 : in2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_md_load) begin
            r_neg_q <= w_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            r_neg_r <= w_signed && !w_is_mul && in1[WIDTH-1];
        end
    end

    always_comb begin
        w_fix_hi = w_md_hi;
        w_fix_lo = w_md_lo;
        w_prod   = -{w_md_hi, w_md_lo};
        if (r_state == MUL) begin
            if (r_neg_q) begin
                w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
                w_fix_lo = w_prod[WIDTH-1:0];
            end
        end else begin
            if (r_neg_q) w_fix_lo = -w_md_lo;
            if (r_neg_r) w_fix_hi = -w_md_hi;
        end
    end
`else
    assign w_signed = 1'b0;
    assign w_a      = in1;
    assign w_b      = in2;
    assign w_fix_hi = w_md_hi;
    assign w_fix_lo = w_md_lo;
`endif

    assign w_is_mul    = (cmd == CMD_MULTU) || (w_signed && (cmd == CMD_MULT));
    assign w_is_muldiv = (cmd == CMD_MULTU) || (cmd == CMD_DIVU) || w_signed;
    assign w_md_load   = (r_state == IDLE) && start && w_is_muldiv;
    assign w_md_step   = (r_state == MUL) || (r_state == DIV);

    mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_md_load),
        .step   (w_md_step),
        .is_div (!w_is_mul),
        .a      (w_a),
        .b      (w_b),
        .last   (w_md_last),
        .nxt_hi (w_md_hi),
        .nxt_lo (w_md_lo)
    );

    // Outputs load only on the edge entering DONE, so they hold across busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_is_muldiv) begin
                            r_busy  <= 1'b1;
                            r_state <= w_is_mul ? MUL : DIV;
                        end else begin
                            r_result <= w_alu;
                            r_hi     <= '0;
                            r_zero   <= (w_alu == '0);
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                MUL, DIV: begin
                    if (w_md_last) begin
                        r_result <= w_fix_lo;
                        r_hi     <= w_fix_hi;
                        r_zero   <= (w_fix_lo == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign hi     = r_hi;
    assign zero   = r_zero;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_alu                                                            |
// | Scoreboard bench for mc_alu with a behavioural reference model.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mc_alu;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   cmd   = 4'd0;
    logic [W-1:0] in1   = '0;
    logic [W-1:0] in2   = '0;
    wire  [W-1:0] result;
    wire  [W-1:0] hi;
    wire          zero;
    wire          busy;
    wire          done;

    mc_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmd    (cmd),
        .in1    (in1),
        .in2    (in2),
        .result (result),
        .hi     (hi),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        int           cyc;
        int           busy;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           checks   = 0;
    int           errors   = 0;
    int           cyc      = 0;
    int           busy_cnt = 0;
    logic [W-1:0] last_res = '0;
    logic [W-1:0] last_hi  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operation's definition.
    task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] h, output int bc);
        logic [2*W-1:0] p;
        int             sh;
        int             sa;
        int             sb;
        sh = int'(b % W);
        sa = $signed(a);
        sb = $signed(b);
        r  = '0;
        h  = '0;
        bc = 0;
        case (c)
            4'b0000: r = a + b;
            4'b0010: r = a - b;
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = ~(a | b);
            4'b0111: r = a ^ b;
            4'b1000: r = a << sh;
            4'b1001: r = sa >>> sh;
            4'b1010: r = a >> sh;
            4'b1011: r = (sa < sb) ? 1 : 0;
            4'b1100: begin
                p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r  = p[W-1:0];
                h  = p[2*W-1:W];
                bc = W;
            end
            4'b1101: begin
                bc = W;
                if (b == 0) begin r = '1; h = a; end
                else begin r = a / b; h = a % b; end
            end
`ifdef MC_ALU_SIGNED_MULDIV_EN
            4'b1110: begin
                p  = 64'(longint'(sa) * longint'(sb));
                r  = p[W-1:0];
                h  = p[2*W-1:W];
                bc = W;
            end
            4'b1111: begin
                bc = W;
                if (b == 0) begin r = (sa < 0) ? 1 : '1; h = a; end
                else if (a == 32'h8000_0000 && b == '1) begin r = a; h = '0; end
                else begin r = sa / sb; h = sa % sb; end
            end
`endif
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input bit blocking);
        @(negedge clk);
        cmd   = c;
        in1   = a;
        in2   = b;
        start = 1'b1;
        e.cyc = cyc + e.busy + 1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cmd   = 4'($urandom);
        in1   = $urandom;
        in2   = $urandom;
        if (blocking) wait_idle();
    endtask

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit blocking);
        exp_t e;
        model(c, a, b, e.res, e.hi, e.busy);
        e.cyc = 0;
        drive(c, a, b, e, blocking);
    endtask

    task automatic issue_x(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic [W-1:0] h, input int bc);
        exp_t e;
        e.res  = r;
        e.hi   = h;
        e.busy = bc;
        e.cyc  = 0;
        drive(c, a, b, e, 1'b1);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            last_res = '0;
            last_hi  = '0;
        end else begin
            if (busy) begin
                busy_cnt++;
                chk("hold_result", result, last_res);
                chk("hold_hi", hi, last_hi);
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("result", result, mon_e.res);
                    chk("hi", hi, mon_e.hi);
                    chk("zero", {31'b0, zero}, {31'b0, (mon_e.res == '0)});
                    chk("latency", W'(cyc), W'(mon_e.cyc));
                    chk("busy_cycles", W'(busy_cnt), W'(mon_e.busy));
                end
                busy_cnt = 0;
                last_res = result;
                last_hi  = hi;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_hi", hi, '0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed single-cycle and mul/div cases with fixed expectations
        issue_x(4'b0010, 32'd5, 32'd7, 32'hFFFF_FFFE, '0, 0);
        issue_x(4'b1001, 32'h8000_0000, 32'h24, 32'hF800_0000, '0, 0);
        issue_x(4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd1, '0, 0);
        issue_x(4'b0110, 32'd0, 32'd0, 32'hFFFF_FFFF, '0, 0);
        issue_x(4'b0000, 32'd4, 32'hFFFF_FFFC, 32'd0, '0, 0);
        issue_x(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32);
        issue_x(4'b1101, 32'd100, 32'd7, 32'd14, 32'd2, 32);
        issue_x(4'b1101, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 32);
`ifdef MC_ALU_SIGNED_MULDIV_EN
        issue_x(4'b1111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
        issue_x(4'b1110, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 32'hFFFF_FFFF, 32);
        issue_x(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32);
`else
        issue_x(4'b1110, 32'd3, 32'd4, 32'd0, 32'd0, 0);
`endif

        // A second start while busy must be ignored
        issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (5) @(negedge clk);
        cmd   = 4'b1101;
        in1   = 32'd1;
        in2   = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset in the middle of a multiply abandons it immediately
        issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, '0);
        chk("midrst_hi", hi, '0);
        chk("midrst_zero", {31'b0, zero}, 32'd1);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue_x(4'b0000, 32'd2, 32'd3, 32'd5, '0, 0);

        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 15)), rnd_op(), rnd_op(), 1'b1);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
